// File: rtl/acs_unit_if.sv
// Branch-metric inputs and decision/metric outputs of one radix-2 ACS stage.
// Latency: n/a (wiring only); the slave modport belongs to acs_unit.
// Backpressure: none, every symbol presented with bm_valid_i is consumed.
// Ports: start_i, bm_valid_i, bm_00_i/bm_11_i/bm_10_i/bm_01_i (source -> ACS);
//        pm0_o..pm3_o, dec_o, dec_valid_o, best_state_o, step_cnt_o (ACS -> sink).
interface acs_unit_if #(
    parameter int PM_W = 6
);
    logic            start_i;
    logic            bm_valid_i;
    logic [1:0]      bm_00_i;
    logic [1:0]      bm_11_i;
    logic [1:0]      bm_10_i;
    logic [1:0]      bm_01_i;
    logic [PM_W-1:0] pm0_o;
    logic [PM_W-1:0] pm1_o;
    logic [PM_W-1:0] pm2_o;
    logic [PM_W-1:0] pm3_o;
    logic [3:0]      dec_o;
    logic            dec_valid_o;
    logic [1:0]      best_state_o;
    logic [15:0]     step_cnt_o;

    modport master (
        output start_i, bm_valid_i, bm_00_i, bm_11_i, bm_10_i, bm_01_i,
        input  pm0_o, pm1_o, pm2_o, pm3_o, dec_o, dec_valid_o, best_state_o, step_cnt_o
    );

    modport slave (
        input  start_i, bm_valid_i, bm_00_i, bm_11_i, bm_10_i, bm_01_i,
        output pm0_o, pm1_o, pm2_o, pm3_o, dec_o, dec_valid_o, best_state_o, step_cnt_o
    );
endinterface

// File: rtl/acs_unit.sv
// Add-compare-select for a 4-state (K=3) Viterbi trellis with survivor decisions.
// Latency: 1 cycle from an accepted symbol to registered metrics/decisions.
// Backpressure: none; every bm_valid_i symbol is consumed on its edge.
// Ports: clk_i, rst_i (async, active-high), bus (acs_unit_if.slave).
// Optional feature: define ACS_NORM_EN to subtract the minimum new metric from all
// four before registering; otherwise each metric saturates at 2^PM_W-1.
module acs_unit #(
    parameter int PM_W    = 6,
    parameter int INIT_PM = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    acs_unit_if.slave    bus
);
    localparam int CW = PM_W + 1;                       // candidate width, never wraps
    localparam logic [PM_W-1:0] PM_MAX  = '1;
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

    logic [PM_W-1:0] pm_q [4];
    logic [3:0]      dec_q;
    logic            dec_vld_q;
    logic [1:0]      best_q;
    logic [15:0]     step_q;

    logic [CW-1:0]   base   [4];
    logic [CW-1:0]   cand_a [4];    // from lower-numbered predecessor
    logic [CW-1:0]   cand_b [4];    // from higher-numbered predecessor
    logic [CW-1:0]   surv   [4];
    logic [CW-1:0]   nrm    [4];
    logic [PM_W-1:0] pm_d   [4];
    logic [3:0]      dec_d;
    logic [1:0]      best_d;
    logic [CW-1:0]   min_c;
    logic [CW-1:0]   b00, b11, b10, b01;

    always_comb begin
        b00 = CW'(bus.bm_00_i);
        b11 = CW'(bus.bm_11_i);
        b10 = CW'(bus.bm_10_i);
        b01 = CW'(bus.bm_01_i);

        // A start coinciding with a symbol uses the initial metrics as predecessors.
        for (int i = 0; i < 4; i++) begin
            if (bus.start_i)
                base[i] = (i == 0) ? '0 : {1'b0, PM_INIT};
            else
                base[i] = {1'b0, pm_q[i]};
        end

        cand_a[0] = base[0] + b00;  cand_b[0] = base[2] + b11;
        cand_a[1] = base[0] + b11;  cand_b[1] = base[2] + b00;
        cand_a[2] = base[1] + b10;  cand_b[2] = base[3] + b01;
        cand_a[3] = base[1] + b01;  cand_b[3] = base[3] + b10;

        // Strict less-than: a tie keeps the lower-numbered predecessor.
        for (int i = 0; i < 4; i++) begin
            dec_d[i] = cand_b[i] < cand_a[i];
            surv[i]  = dec_d[i] ? cand_b[i] : cand_a[i];
        end

        min_c = surv[0];
        for (int i = 1; i < 4; i++) begin
            if (surv[i] < min_c)
                min_c = surv[i];
        end

        for (int i = 0; i < 4; i++) begin
`ifdef ACS_NORM_EN
            nrm[i] = surv[i] - min_c;
`else
            nrm[i] = surv[i];
`endif
            pm_d[i] = (nrm[i] > {1'b0, PM_MAX}) ? PM_MAX : nrm[i][PM_W-1:0];
        end

        best_d = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm_d[i] < pm_d[best_d])
                best_d = 2'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pm_q[0]   <= '0;
            pm_q[1]   <= PM_INIT;
            pm_q[2]   <= PM_INIT;
            pm_q[3]   <= PM_INIT;
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
            best_q    <= '0;
            step_q    <= '0;
        end else if (bus.bm_valid_i) begin
            for (int i = 0; i < 4; i++)
                pm_q[i] <= pm_d[i];
            dec_q     <= dec_d;
            dec_vld_q <= 1'b1;
            best_q    <= best_d;
            step_q    <= bus.start_i ? 16'd1 : step_q + 16'd1;
        end else if (bus.start_i) begin
            pm_q[0]   <= '0;
            pm_q[1]   <= PM_INIT;
            pm_q[2]   <= PM_INIT;
            pm_q[3]   <= PM_INIT;
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
            best_q    <= '0;
            step_q    <= '0;
        end else begin
            dec_vld_q <= 1'b0;
        end
    end

    assign bus.pm0_o        = pm_q[0];
    assign bus.pm1_o        = pm_q[1];
    assign bus.pm2_o        = pm_q[2];
    assign bus.pm3_o        = pm_q[3];
    assign bus.dec_o        = dec_q;
    assign bus.dec_valid_o  = dec_vld_q;
    assign bus.best_state_o = best_q;
    assign bus.step_cnt_o   = step_q;
endmodule

// File: tb/tb_acs_unit.sv
// Directed bench for acs_unit (PM_W=6, INIT_PM=8) with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expectations that depend on ACS_NORM_EN follow the same macro.
module tb_acs_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    acs_unit_if #(.PM_W(6)) bus ();

    acs_unit #(.PM_W(6), .INIT_PM(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_pm(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, ".pm0"}, 32'(bus.pm0_o), e0);
        check({tag, ".pm1"}, 32'(bus.pm1_o), e1);
        check({tag, ".pm2"}, 32'(bus.pm2_o), e2);
        check({tag, ".pm3"}, 32'(bus.pm3_o), e3);
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic s, input logic v,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        @(negedge clk);
        bus.start_i    = s;
        bus.bm_valid_i = v;
        bus.bm_00_i    = a;
        bus.bm_11_i    = b;
        bus.bm_10_i    = c;
        bus.bm_01_i    = d;
        @(posedge clk);
        #1;
        bus.start_i    = 1'b0;
        bus.bm_valid_i = 1'b0;
    endtask

    // Mid-cycle reset: values must appear without any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_pm(tag, 0, 8, 8, 8);
        check({tag, ".dec"},  32'(bus.dec_o), 0);
        check({tag, ".dv"},   32'(bus.dec_valid_o), 0);
        check({tag, ".best"}, 32'(bus.best_state_o), 0);
        check({tag, ".step"}, 32'(bus.step_cnt_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.bm_valid_i = 1'b0;
        bus.bm_00_i    = 2'd0;
        bus.bm_11_i    = 2'd0;
        bus.bm_10_i    = 2'd0;
        bus.bm_01_i    = 2'd0;
        #1;
        check_pm("por", 0, 8, 8, 8);
        check("por.dec",  32'(bus.dec_o), 0);
        check("por.dv",   32'(bus.dec_valid_o), 0);
        check("por.step", 32'(bus.step_cnt_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // bm=(0,2,1,1): S2/S3 ties resolve to the lower predecessor
        step(1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 2'd1);
        check_pm("sym_a", 0, 2, 9, 9);
        check("sym_a.dec",  32'(bus.dec_o), 0);
        check("sym_a.best", 32'(bus.best_state_o), 0);
        check("sym_a.dv",   32'(bus.dec_valid_o), 1);
        check("sym_a.step", 32'(bus.step_cnt_o), 1);

        // reset while dec_valid_o is high
        do_reset("rst_mid");

        // bm=(2,0,1,1): S1 is the best state
        step(1'b0, 1'b1, 2'd2, 2'd0, 2'd1, 2'd1);
        check_pm("sym_b", 2, 0, 9, 9);
        check("sym_b.dec",  32'(bus.dec_o), 0);
        check("sym_b.best", 32'(bus.best_state_o), 1);
        check("sym_b.step", 32'(bus.step_cnt_o), 1);

        do_reset("rst_b");

        // bm=(1,1,2,0): S2 takes its survivor from S3
        step(1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 2'd0);
`ifdef ACS_NORM_EN
        check_pm("sym_c", 0, 0, 7, 7);
`else
        check_pm("sym_c", 1, 1, 8, 8);
`endif
        check("sym_c.dec",  32'(bus.dec_o), 4'b0100);
        check("sym_c.best", 32'(bus.best_state_o), 0);

        // three idle cycles: everything holds, dec_valid_o drops
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("gap.dv", 32'(bus.dec_valid_o), 0);
        end
`ifdef ACS_NORM_EN
        check_pm("gap", 0, 0, 7, 7);
`else
        check_pm("gap", 1, 1, 8, 8);
`endif
        check("gap.dec",  32'(bus.dec_o), 4'b0100);
        check("gap.step", 32'(bus.step_cnt_o), 1);

        // start together with a symbol restarts from the initial metrics
        step(1'b1, 1'b1, 2'd0, 2'd2, 2'd1, 2'd1);
        check_pm("start_sym", 0, 2, 9, 9);
        check("start_sym.step", 32'(bus.step_cnt_o), 1);
        check("start_sym.dv",   32'(bus.dec_valid_o), 1);
        check("start_sym.dec",  32'(bus.dec_o), 0);

        // start alone reinitialises without a decision
        step(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check_pm("start_only", 0, 8, 8, 8);
        check("start_only.step", 32'(bus.step_cnt_o), 0);
        check("start_only.dv",   32'(bus.dec_valid_o), 0);
        check("start_only.dec",  32'(bus.dec_o), 0);

        // two back-to-back symbols
        step(1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 2'd1);
        check("b2b1.step", 32'(bus.step_cnt_o), 1);
        step(1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 2'd1);
        check_pm("b2b2", 0, 2, 3, 3);
        check("b2b2.step", 32'(bus.step_cnt_o), 2);
        check("b2b2.dv",   32'(bus.dec_valid_o), 1);

        // 40 worst-case symbols: saturate at 63, or stay normalised to 0
        do_reset("rst_sat");
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 2'd2);
`ifdef ACS_NORM_EN
        check_pm("sat", 0, 0, 0, 0);
`else
        check_pm("sat", 63, 63, 63, 63);
`endif
        check("sat.dec",  32'(bus.dec_o), 0);
        check("sat.best", 32'(bus.best_state_o), 0);
        check("sat.step", 32'(bus.step_cnt_o), 40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 Parameter PM_W, default 6, path-metric width in bits (minimum 4).
REQ-002 Parameter INIT_PM, default 8, initial metric of states S1..S3 (must be < 2^PM_W).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  frame start; reinitialises metrics and counter.
REQ-006 bm_valid_i  input  1  branch-metric set valid this cycle.
REQ-007 bm_00_i, bm_11_i, bm_10_i, bm_01_i  input  2 each  Hamming distance of the received symbol to codewords 00, 11, 10, 01 (values 0..2).
REQ-008 pm0_o..pm3_o  output  PM_W each  registered path metric of S0..S3.
REQ-009 dec_o  output  4  survivor decision, bit i for state Si.
REQ-010 dec_valid_o  output  1  dec_o/pm*_o updated by an accepted symbol.
REQ-011 best_state_o  output  2  index of the minimum registered metric.
REQ-012 step_cnt_o  output  16  accepted symbols since last start/reset.

Function
REQ-013 Trellis (S=2-bit state, shift-left encoder): S0 fed by S0 (codeword 00) and S2 (11); S1 fed by S0 (11) and S2 (00); S2 fed by S1 (10) and S3 (01); S3 fed by S1 (01) and S3 (10).
REQ-014 Candidate = predecessor metric + branch metric, computed at PM_W+1 bits with no wrap.
REQ-015 Each new metric = smaller candidate; dec bit = 0 if the lower-numbered predecessor wins, 1 otherwise; a tie selects the lower-numbered predecessor (bit 0).
REQ-016 On a cycle with bm_valid_i=1, metrics, dec_o and best_state_o register the new values at that edge (latency 1 cycle); dec_valid_o=1 for exactly that following cycle.
REQ-017 With bm_valid_i=0, metrics, dec_o, best_state_o and step_cnt_o hold; dec_valid_o=0.
REQ-018 start_i=1 alone: pm0=0, pm1..pm3=INIT_PM, step_cnt_o=0, dec_o=0, dec_valid_o=0 next cycle.
REQ-019 start_i=1 with bm_valid_i=1: the step uses the initial metrics of REQ-018 as predecessors; step_cnt_o becomes 1; dec_valid_o=1.
REQ-020 best_state_o: index of the minimum new metric; ties resolve to the lowest index.
REQ-021 step_cnt_o increments by 1 per accepted symbol, wrapping 65535 -> 0 without side effects.
REQ-022 Bus valid_i semantics: no backpressure; every valid symbol is consumed.

Reset
REQ-023 rst_i asserted: immediately pm0_o=0, pm1_o..pm3_o=INIT_PM, dec_o=0, dec_valid_o=0, best_state_o=0, step_cnt_o=0, independent of clk_i.
REQ-024 rst_i asserted mid-frame discards all state; first accepted symbol after release behaves as REQ-019 without start_i.
REQ-025 rst_i deassertion takes effect at the next rising edge; inputs sampled that edge are processed normally.

Configuration
REQ-026 Macro ACS_NORM_EN defined: after the compare-select, the minimum of the four new metrics is subtracted from all four before registering (minimum registered metric always 0); any value still above 2^PM_W-1 is clamped to 2^PM_W-1.
REQ-027 Macro ACS_NORM_EN undefined: no subtraction; each new metric saturates at 2^PM_W-1 (63 for PM_W=6) and stays there while candidates exceed it.

Verification (PM_W=6, INIT_PM=8)
REQ-028 Assert rst_i -> pm0..pm3 = 0,8,8,8; dec_o=0; dec_valid_o=0; step_cnt_o=0, without a clock edge.
REQ-029 After reset, one symbol with bm(00,11,10,01)=(0,2,1,1) -> next cycle pm=0,2,9,9; dec_o=4'b0000; best_state_o=0; dec_valid_o=1; step_cnt_o=1.
REQ-030 After reset, one symbol with bm=(2,0,1,1) -> pm=2,0,9,9; dec_o=4'b0000; best_state_o=1.
REQ-031 After reset, one symbol with bm=(1,1,2,0) -> dec_o=4'b0100; pm=0,0,7,7 with ACS_NORM_EN, pm=1,1,8,8 without.
REQ-032 Without ACS_NORM_EN, 40 symbols with bm=(2,2,2,2) -> all metrics reach 63 and hold; with ACS_NORM_EN, metrics stay 0,8,8,8-derived bounded and min=0 every step.
REQ-033 Mid-stream: bm_valid_i low 3 cycles then start_i with bm_valid_i and bm=(0,2,1,1) -> outputs held during gap, then pm=0,2,9,9, step_cnt_o=1.
